vga_rx_monitor: RTL

Receive-side counterpart of the 640x480@60 VGA timing generator. It samples the VGA bus (pixel clock, HS, VS, RGB) in the CLOCK_50 domain and checks every line and frame against the 800x525 timing. Once timing is locked, it recovers active-area pixel coordinates and emits one write strobe per active pixel. It is used in loopback benches and as the front end of the on-chip frame-capture path.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_bus_sampler.sv | 55 +++++
 rtl/vga_rx_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA generator and the receive monitor,
// plus the monitor's lock state encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_H_ACT       = 640;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_ACT_START = 35;
  localparam int unsigned VGA_V_ACT       = 480;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } mon_state_t;

endpackage

// File: rtl/vga_bus_sampler.sv
// Two-stage capture of the VGA bus in the CLOCK_50 domain; produces a pixel-clock
// tick and sync edge pulses, all qualified by tick.
module vga_bus_sampler (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        tick,
  output logic        hs_fall,
  output logic        hs_rise,
  output logic        vs_fall,
  output logic        vs_rise,
  output logic [23:0] rgb
);

  logic clk_q1, hs_q1, vs_q1;
  logic clk_q2, hs_q2, vs_q2;

  // hs_q2/vs_q2 hold the sync levels seen at the previous tick, so an edge is
  // recognised on the tick even if sync moves on the other pixel-clock phase.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      clk_q1 <= 1'b0;
      hs_q1  <= 1'b0;
      vs_q1  <= 1'b0;
      rgb    <= '0;
      clk_q2 <= 1'b0;
      hs_q2  <= 1'b0;
      vs_q2  <= 1'b0;
    end else begin
      clk_q1 <= VGA_CLK;
      hs_q1  <= VGA_HS;
      vs_q1  <= VGA_VS;
      rgb    <= {VGA_R, VGA_G, VGA_B};
      clk_q2 <= clk_q1;
      if (tick) begin
        hs_q2 <= hs_q1;
        vs_q2 <= vs_q1;
      end
    end
  end

  always_comb begin
    tick    = clk_q1 & ~clk_q2;
    hs_fall = tick & ~hs_q1 &  hs_q2;
    hs_rise = tick &  hs_q1 & ~hs_q2;
    vs_fall = tick & ~vs_q1 &  vs_q2;
    vs_rise = tick &  vs_q1 & ~vs_q2;
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: checks line/frame timing, tracks lock, and emits one
// registered strobe with coordinates and colour per active pixel once locked.
module vga_rx_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACT       = VGA_H_ACT,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACT       = VGA_V_ACT,
  parameter int unsigned CHECK_BLANK = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [7:0]  px_r,
  output logic [7:0]  px_g,
  output logic [7:0]  px_b,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_SW   = HCNT_W'(H_SYNC);
  localparam logic [HCNT_W-1:0] H_A0   = HCNT_W'(H_ACT_START);
  localparam logic [HCNT_W-1:0] H_A1   = HCNT_W'(H_ACT_START + H_ACT);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_SW   = VCNT_W'(V_SYNC);
  localparam logic [VCNT_W-1:0] V_A0   = VCNT_W'(V_ACT_START);
  localparam logic [VCNT_W-1:0] V_A1   = VCNT_W'(V_ACT_START + V_ACT);

  logic              tick, hs_fall, hs_rise, vs_fall, vs_rise;
  logic [23:0]       rgb;
  logic [HCNT_W-1:0] hcount, h_new;
  logic [VCNT_W-1:0] vcount, v_new;
  mon_state_t        state, state_d;
  logic              active, err_hit, px_fire, fs_fire;

  vga_bus_sampler u_sampler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .VGA_CLK  (VGA_CLK),
    .VGA_HS   (VGA_HS),
    .VGA_VS   (VGA_VS),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .tick     (tick),
    .hs_fall  (hs_fall),
    .hs_rise  (hs_rise),
    .vs_fall  (vs_fall),
    .vs_rise  (vs_rise),
    .rgb      (rgb)
  );

  // h_new/v_new are the coordinates of the pixel carried by this tick; window,
  // sync-width checks and output coordinates all use them.
  always_comb begin
    h_new = hs_fall ? '0 : hcount + 1'b1;
    v_new = vcount;
    if (hs_fall) begin
      v_new = vs_fall ? '0 : vcount + 1'b1;
    end
    active = (h_new >= H_A0) && (h_new < H_A1) && (v_new >= V_A0) && (v_new < V_A1);
  end

  always_comb begin
    err_hit = 1'b0;
    if (tick && state != SEARCH) begin
      if (hs_fall && hcount != H_LAST)                 err_hit = 1'b1;
      if (!hs_fall && hcount == H_LAST)                err_hit = 1'b1;
      if (hs_rise && h_new != H_SW)                    err_hit = 1'b1;
      if (vs_fall && vcount != V_LAST)                 err_hit = 1'b1;
      if (vs_rise && (!hs_fall || v_new != V_SW))      err_hit = 1'b1;
      if (CHECK_BLANK != 0 && rgb != '0 && !active)    err_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    if (tick) begin
      case (state)
        SEARCH:  if (vs_fall) state_d = ACQUIRE;
        ACQUIRE: begin
          if (err_hit)      state_d = SEARCH;
          else if (vs_fall) state_d = LOCKED;
        end
        LOCKED:  if (err_hit) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase
    end
    px_fire = tick && state == LOCKED && active && !err_hit;
    fs_fire = vs_fall && state_d == LOCKED;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) state <= SEARCH;
    else        state <= state_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      hcount      <= '0;
      vcount      <= '0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_r        <= '0;
      px_g        <= '0;
      px_b        <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      if (tick) begin
        hcount <= h_new;
        vcount <= v_new;
      end
      px_valid    <= px_fire;
      px_x        <= px_fire ? 10'(h_new - H_A0) : '0;
      px_y        <= px_fire ? 10'(v_new - V_A0) : '0;
      px_r        <= px_fire ? rgb[23:16] : '0;
      px_g        <= px_fire ? rgb[15:8]  : '0;
      px_b        <= px_fire ? rgb[7:0]   : '0;
      frame_start <= fs_fire;
      locked      <= (state_d == LOCKED);
      if (err_hit && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
